// File: rtl/reduceron_io_pkg.sv
// Shared definitions for the Reduceron IO console block.
//   CONSOLE_ADDR / STATUS_ADDR / DROP_ADDR : IO address map
//   STATUS_BUSY / STATUS_EMPTY / STATUS_FULL : bit positions in the status word
//   tx_state_t : UART transmitter states
package reduceron_io_pkg;

    localparam int CONSOLE_ADDR = 0;
    localparam int STATUS_ADDR  = 1;
    localparam int DROP_ADDR    = 2;

    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_EMPTY = 1;
    localparam int STATUS_FULL  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/reduceron_io_uart_if.sv
// Reduceron core memory-mapped IO bus.
//   ioaddr  : IO address (core -> device)
//   iowrite : one-cycle write strobe
//   ioread  : one-cycle read strobe
//   iowd    : write data
//   iord    : registered read data (device -> core)
// master modport is the core side, slave modport is the device side.
interface reduceron_io_uart_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 15
);
    logic [ADDR_W-1:0] ioaddr;
    logic              iowrite;
    logic              ioread;
    logic [DATA_W-1:0] iowd;
    logic [DATA_W-1:0] iord;

    modport master (output ioaddr, output iowrite, output ioread, output iowd, input iord);
    modport slave  (input ioaddr, input iowrite, input ioread, input iowd, output iord);
endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO for the console byte stream.
//   clock, reset_n : clock and asynchronous active-low reset
//   push, din      : write side; a push while full is ignored
//   pop, dout      : read side; dout shows the head combinationally,
//                    a pop while empty is ignored
//   full, empty    : occupancy flags
//   level          : number of stored entries (log2(DEPTH)+1 bits)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage holds data only, so it is not reset.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/reduceron_io_uart.sv
// Reduceron IO console: decodes console writes from the core IO bus,
// buffers bytes in a FIFO and transmits them 8N1 on uart_tx.
//   clock, reset_n : clock and asynchronous active-low reset
//   io (slave)     : core IO bus; address 0 = console write,
//                    1 = status read, 2 = dropped-write counter read
//   uart_tx        : registered serial output, idle high
//   tx_busy        : high while a frame is on the line
//   fifo_full      : console FIFO holds FIFO_DEPTH bytes
//   drop_count     : dropped console writes
// Build option REDUCERON_IO_DROP_COUNT_EN: when defined, drop_count counts
// (saturating) writes dropped on a full FIFO and a read of address 2
// returns and clears it; when undefined, drop_count is 0 and address 2 reads 0.
module reduceron_io_uart
    import reduceron_io_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    reduceron_io_uart_if.slave  io,
    output logic                uart_tx,
    output logic                tx_busy,
    output logic                fifo_full,
    output logic [15:0]         drop_count
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    logic              wr_console;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] iord_q;

    tx_state_t         state, state_n;
    logic [CW-1:0]     baud_cnt, baud_cnt_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [7:0]        shreg, shreg_n;
    logic              baud_end;
    logic              tx_q;
    logic              busy_q;

    assign wr_console = io.iowrite && (io.ioaddr == ADDR_W'(CONSOLE_ADDR));

    // The FIFO ignores a push while full, so a write that meets a full FIFO
    // is dropped even if the transmitter pops in the same cycle.
    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (wr_console),
        .pop     (fifo_pop),
        .din     (io.iowd[7:0]),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Status is built from pre-edge state, so a same-cycle write is not visible.
    always_comb begin
        status                 = '0;
        status[DATA_W-1:3]     = (DATA_W - 3)'(fifo_level);
        status[STATUS_FULL]    = fifo_full;
        status[STATUS_EMPTY]   = fifo_empty;
        status[STATUS_BUSY]    = busy_q;
    end

`ifdef REDUCERON_IO_DROP_COUNT_EN
    logic        drop;
    logic        rd_drop;
    logic [15:0] drop_cnt;

    assign drop    = wr_console && fifo_full;
    assign rd_drop = io.ioread && (io.ioaddr == ADDR_W'(DROP_ADDR));

    // A read clears the counter; a drop landing on the clearing read leaves 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (rd_drop) begin
            drop_cnt <= drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif

    always_comb begin
        rd_data = '0;
        if (io.ioaddr == ADDR_W'(STATUS_ADDR))
            rd_data = status;
`ifdef REDUCERON_IO_DROP_COUNT_EN
        else if (io.ioaddr == ADDR_W'(DROP_ADDR))
            rd_data = DATA_W'(drop_cnt);
`endif
    end

    // Read data holds until the next read strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        iord_q <= '0;
        else if (io.ioread)  iord_q <= rd_data;
    end

    assign io.iord = iord_q;

    assign baud_end = (baud_cnt == CW'(DIV - 1));

    // TX FSM next-state logic; a pop loads the shift register from the FIFO head.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        fifo_pop   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_n    = fifo_dout;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    shreg_n    = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (!fifo_empty) begin
                        // Back-to-back frame: no idle bit between stop and start.
                        fifo_pop  = 1'b1;
                        shreg_n   = fifo_dout;
                        bit_idx_n = '0;
                        state_n   = START;
                    end else begin
                        state_n   = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line and busy are registered from the current state, so they trail
    // the FSM by one cycle and are glitch-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            tx_q     <= (state == START) ? 1'b0 :
                        (state == DATA)  ? shreg[0] : 1'b1;
            busy_q   <= (state != IDLE);
        end
    end

    always_ff @(posedge clock) begin
        shreg <= shreg_n;
    end

    assign uart_tx = tx_q;
    assign tx_busy = busy_q;

endmodule
